// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the 9-bit core's encoder and decoder.
// Contents:
//   INSTR_W     - instruction word width
//   op_e        - 4-bit mnemonic codes in ISA order (15 is not a mnemonic)
//   OPC_*       - 3-bit major opcodes, instruction bits [8:6]
//   SUB_*       - 2-bit minor opcodes, instruction bits [1:0]
package isa_pkg;

  localparam int INSTR_W = 9;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_SLT  = 4'd1,
    OP_OR   = 4'd2,
    OP_JR   = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_ADD  = 4'd6,
    OP_ADDI = 4'd7,
    OP_TR   = 4'd8,
    OP_BEQ  = 4'd9,
    OP_SUB  = 4'd10,
    OP_SRL  = 4'd11,
    OP_SRA  = 4'd12,
    OP_SLL  = 4'd13,
    OP_HALT = 4'd14,
    OP_BAD  = 4'd15
  } op_e;

  localparam logic [2:0] OPC_ALU   = 3'b000;
  localparam logic [2:0] OPC_MEM   = 3'b001;
  localparam logic [2:0] OPC_ADD   = 3'b010;
  localparam logic [2:0] OPC_ADDI  = 3'b011;
  localparam logic [2:0] OPC_TR    = 3'b100;
  localparam logic [2:0] OPC_BEQ   = 3'b101;
  localparam logic [2:0] OPC_SUB   = 3'b110;
  localparam logic [2:0] OPC_SHIFT = 3'b111;

  localparam logic [1:0] SUB_AND  = 2'b00;
  localparam logic [1:0] SUB_SLT  = 2'b01;
  localparam logic [1:0] SUB_OR   = 2'b10;
  localparam logic [1:0] SUB_JR   = 2'b11;
  localparam logic [1:0] SUB_LW   = 2'b00;
  localparam logic [1:0] SUB_SW   = 2'b01;
  localparam logic [1:0] SUB_SRL  = 2'b00;
  localparam logic [1:0] SUB_SRA  = 2'b01;
  localparam logic [1:0] SUB_SLL  = 2'b10;
  localparam logic [1:0] SUB_HALT = 2'b11;

endpackage

// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if: mnemonic-plus-field beat stream into the encoder.
// Signals:
//   in_valid  - source has a beat on in_op/in_fa/in_fb/in_fc
//   in_ready  - sink can take a beat this cycle
//   in_op     - mnemonic code (op_e)
//   in_fa     - field A: rs [1:0], or TR destination [2:0]
//   in_fb     - field B: rt/rd [1:0], or TR source [2:0]
//   in_fc     - field C: rd (ADD/SUB) or imm (ADDI)
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready may fall without a transfer; the source
// holds its beat stable while in_valid=1 and in_ready=0.
interface instr_stream_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_fa;
  logic [2:0] in_fb;
  logic [1:0] in_fc;

  modport master (
    output in_valid, in_op, in_fa, in_fb, in_fc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_fa, in_fb, in_fc,
    output in_ready
  );
endinterface

// File: rtl/instr_encode.sv
// instr_encode: purely combinational mnemonic-to-ISA-word packer.
// Ports:
//   op      in  4        mnemonic code (op_e)
//   fa      in  3        field A
//   fb      in  3        field B
//   fc      in  2        field C
//   word    out INSTR_W  packed instruction {opcode[8:6], bits[5:0]}
//   illegal out 1        op is not a mnemonic; word is 0
// Field bits a given format does not use are ignored.
module instr_encode
  import isa_pkg::*;
(
  input  logic [3:0]         op,
  input  logic [2:0]         fa,
  input  logic [2:0]         fb,
  input  logic [1:0]         fc,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  word = {OPC_ALU,   fa[1:0], fb[1:0], SUB_AND};
      OP_SLT:  word = {OPC_ALU,   fa[1:0], fb[1:0], SUB_SLT};
      OP_OR:   word = {OPC_ALU,   fa[1:0], fb[1:0], SUB_OR};
      OP_JR:   word = {OPC_ALU,   fa[1:0], fb[1:0], SUB_JR};
      OP_LW:   word = {OPC_MEM,   fa[1:0], fb[1:0], SUB_LW};
      OP_SW:   word = {OPC_MEM,   fa[1:0], fb[1:0], SUB_SW};
      OP_ADD:  word = {OPC_ADD,   fa[1:0], fb[1:0], fc};
      OP_ADDI: word = {OPC_ADDI,  fa[1:0], 2'b00,   fc};
      OP_TR:   word = {OPC_TR,    fa,      fb};
      OP_BEQ:  word = {OPC_BEQ,   fa[1:0], fb[1:0], 2'b00};
      OP_SUB:  word = {OPC_SUB,   fa[1:0], fb[1:0], fc};
      OP_SRL:  word = {OPC_SHIFT, fa[1:0], fb[1:0], SUB_SRL};
      OP_SRA:  word = {OPC_SHIFT, fa[1:0], fb[1:0], SUB_SRA};
      OP_SLL:  word = {OPC_SHIFT, fa[1:0], fb[1:0], SUB_SLL};
      // HALT shares the shift opcode with zeroed register fields.
      OP_HALT: word = {OPC_SHIFT, 4'b0000, SUB_HALT};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs a stream of mnemonic beats into 9-bit ISA
// words and writes them to consecutive instruction memory addresses,
// starting at a base address captured on start.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse: begin a new session (wins over any beat)
//   base_addr   first write address, sampled on start
//   in_if       beat stream (slave side)
//   imem_we     write strobe, one cycle after the beat was accepted
//   imem_addr   write address = base + count, wrapping modulo 2^ADDR_W
//   imem_wdata  encoded word
//   busy        session is loading
//   done        pulse alongside the HALT word's write
//   err         sticky: illegal mnemonic or overflow; cleared by start
//   count       words written this session
//   state_dbg   current FSM state
module instr_stream_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  instr_stream_encoder_if.slave in_if,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    count,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [1:0]         state;
  logic [ADDR_W-1:0]  base_q;
  logic [INSTR_W-1:0] enc_word;
  logic               enc_illegal;
  logic               accept;
  logic               overflow;
  logic               is_halt;
  logic [ADDR_W-1:0]  wr_addr;

  instr_encode u_encode (
    .op      (in_if.in_op),
    .fa      (in_if.in_fa),
    .fb      (in_if.in_fb),
    .fc      (in_if.in_fc),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // A beat offered in the same cycle as start is refused so the new
  // session always begins from an empty count.
  assign in_if.in_ready = (state == ST_LOAD) & ~start;
  assign accept         = in_if.in_valid & in_if.in_ready;
  assign overflow       = (count == DEPTH_C);
  assign is_halt        = (in_if.in_op == OP_HALT);
  // Address arithmetic is ADDR_W wide so it wraps silently.
  assign wr_addr        = base_q + count[ADDR_W-1:0];

  assign busy      = (state == ST_LOAD);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start) begin
        // Any write registered last cycle is already on the outputs and
        // completes at its old address; only future writes move.
        state  <= ST_LOAD;
        count  <= '0;
        err    <= 1'b0;
        base_q <= base_addr;
      end else if (accept) begin
        if (enc_illegal || overflow) begin
          state <= ST_ERR;
          err   <= 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= wr_addr;
          imem_wdata <= enc_word;
          count      <= count + ONE_C;
          if (is_halt) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
